load_store_unit: RTL and testbench

//  Parametrised load/store unit between the core's execute stage and a handshaked data memory.

---
 rtl/load_store_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a handshaked data memory.
// Computes the effective address, steers store lanes and extracts/extends load data.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_is_store,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_base,
    input  logic [XLEN-1:0]     req_offset,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [4:0]          req_rd,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_rerr,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_wen,
    output logic [4:0]          resp_rd,
    output logic [XLEN-1:0]     resp_data,
    output logic [1:0]          resp_err,
    output logic [XLEN-1:0]     resp_addr
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic [2:0]      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] ea_q, ea_d;
    logic [NB-1:0]   wstrb_q, wstrb_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [1:0]      err_q, err_d;
    logic            wen_q, wen_d;

    logic [XLEN-1:0] ea_s;
    logic [OFFW-1:0] off_s;
    logic [XLEN-1:0] ld_data_s;

    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            m[i] = (i < (1 << sz));
        end
        return m;
    endfunction

    // Truncate to the access size, then sign- or zero-extend to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] s, input logic [2:0] f3);
        int              w;
        logic            sgn;
        logic [XLEN-1:0] r;
        w   = ((8 << f3[1:0]) > XLEN) ? XLEN : (8 << f3[1:0]);
        sgn = ~f3[2] & s[w-1];
        for (int i = 0; i < XLEN; i++) begin
            r[i] = (i < w) ? s[i] : sgn;
        end
        return r;
    endfunction

    function automatic logic is_illegal(input logic st, input logic [2:0] f3);
        return (f3 == 3'b111) || (st && f3[2]) ||
               ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] lo);
        logic r;
        case (sz)
            2'b00:   r = 1'b0;
            2'b01:   r = lo[0];
            2'b10:   r = (lo[1:0] != 2'b00);
            default: r = (lo != 3'b000);
        endcase
        return r;
    endfunction

    assign ea_s      = req_base + req_offset;
    assign off_s     = ea_s[OFFW-1:0];
    assign ld_data_s = extend(mem_rdata >> {ea_q[OFFW-1:0], 3'b000}, f3_q);

    // Next-state and capture logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        ea_d    = ea_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wen_d   = wen_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_is_store;
                    f3_d    = req_funct3;
                    ea_d    = ea_s;
                    rd_d    = req_rd;
                    wstrb_d = req_is_store ? (size_mask(req_funct3[1:0]) << off_s) : '0;
                    wdata_d = req_is_store ? (req_wdata << {off_s, 3'b000}) : '0;
                    rdata_d = '0;
                    wen_d   = 1'b0;
                    if (is_illegal(req_is_store, req_funct3)) begin
                        state_d = ST_ERR;
                        err_d   = 2'b10;
                    end else if (is_misaligned(req_funct3[1:0], ea_s[2:0])) begin
                        state_d = ST_ERR;
                        err_d   = 2'b01;
                    end else begin
                        state_d = ST_REQ;
                        err_d   = 2'b00;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A load may be granted and answered in the same cycle.
                if (mem_gnt && (we_q || mem_rvalid)) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        err_d   = mem_rerr ? 2'b11 : 2'b00;
                        rdata_d = mem_rerr ? '0 : ld_data_s;
                        wen_d   = ~mem_rerr & (rd_q != 5'd0);
                    end else begin
                        err_d   = 2'b00;
                    end
                end else if (mem_gnt) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_RESP;
                    err_d   = mem_rerr ? 2'b11 : 2'b00;
                    rdata_d = mem_rerr ? '0 : ld_data_s;
                    wen_d   = ~mem_rerr & (rd_q != 5'd0);
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            ea_q    <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rd_q    <= 5'd0;
            rdata_q <= '0;
            err_q   <= 2'b00;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            ea_q    <= ea_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_req    = (state_q == ST_REQ);
    assign mem_we     = we_q;
    assign mem_addr   = {ea_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = wdata_q;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_wen   = wen_q;
    assign resp_rd    = rd_q;
    assign resp_data  = rdata_q;
    assign resp_err   = err_q;
    assign resp_addr  = ea_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with an in-bench reference model,
// plus directed cases pinning known results for XLEN=32 and XLEN=64.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_offset, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_rerr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        resp_valid, resp_ready, resp_wen;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data, resp_addr;
    logic [1:0]  resp_err;

    load_store_unit #(.XLEN(32)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wen(resp_wen),
        .resp_rd(resp_rd), .resp_data(resp_data), .resp_err(resp_err), .resp_addr(resp_addr)
    );

    logic        req_valid6, req_ready6, req_is_store6;
    logic [2:0]  req_funct36;
    logic [63:0] req_base6, req_offset6, req_wdata6;
    logic        mem_req6, mem_we6, mem_gnt6, mem_rvalid6, mem_rerr6;
    logic [63:0] mem_addr6, mem_wdata6, mem_rdata6;
    logic [7:0]  mem_wstrb6;
    logic        resp_valid6, resp_wen6;
    logic [4:0]  resp_rd6;
    logic [63:0] resp_data6, resp_addr6;
    logic [1:0]  resp_err6;

    load_store_unit #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid6), .req_ready(req_ready6), .req_is_store(req_is_store6),
        .req_funct3(req_funct36), .req_base(req_base6), .req_offset(req_offset6),
        .req_wdata(req_wdata6), .req_rd(5'd7),
        .mem_req(mem_req6), .mem_we(mem_we6), .mem_addr(mem_addr6), .mem_wstrb(mem_wstrb6),
        .mem_wdata(mem_wdata6), .mem_gnt(mem_gnt6), .mem_rvalid(mem_rvalid6),
        .mem_rdata(mem_rdata6), .mem_rerr(mem_rerr6),
        .resp_valid(resp_valid6), .resp_ready(1'b1), .resp_wen(resp_wen6),
        .resp_rd(resp_rd6), .resp_data(resp_data6), .resp_err(resp_err6), .resp_addr(resp_addr6)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs, set by the driver from the model.
    bit          chk_on = 1'b0;
    logic        e_req_ready, e_mem_req, e_resp_valid, e_we, e_wen;
    logic [31:0] e_addr, e_wdata, e_data, e_raddr;
    logic [3:0]  e_strb;
    logic [4:0]  e_rd;
    logic [1:0]  e_err;

    int          txn_id = 0, last_id = -1, acc_cyc = 0;
    bit          rec_mr_seen;
    int          rec_mr_cyc, rec_rv_cyc, rec_rv_cnt;
    logic [31:0] rec_addr, rec_wdata, rec_data, rec_raddr;
    logic [3:0]  rec_strb;
    logic        rec_wen;
    logic [1:0]  rec_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (txn_id != last_id) begin
            last_id     = txn_id;
            rec_mr_seen = 1'b0;
            rec_mr_cyc  = -1;
            rec_rv_cyc  = -1;
            rec_rv_cnt  = 0;
        end
        if (chk_on && !rst) begin
            chk("req_ready", req_ready, e_req_ready);
            chk("mem_req", mem_req, e_mem_req);
            chk("resp_valid", resp_valid, e_resp_valid);
            if (e_mem_req) begin
                chk("mem_we", mem_we, e_we);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", mem_wstrb, e_strb);
                for (int i = 0; i < 4; i++)
                    if (e_strb[i]) chk("mem_wdata_lane", mem_wdata[8*i +: 8], e_wdata[8*i +: 8]);
            end
            if (e_resp_valid) begin
                chk("resp_wen", resp_wen, e_wen);
                chk("resp_rd", resp_rd, e_rd);
                chk("resp_data", resp_data, e_data);
                chk("resp_err", resp_err, e_err);
                chk("resp_addr", resp_addr, e_raddr);
            end
        end
        if (mem_req) begin
            if (!rec_mr_seen) rec_mr_cyc = cyc;
            rec_mr_seen = 1'b1;
            rec_addr    = mem_addr;
            rec_strb    = mem_wstrb;
            rec_wdata   = mem_wdata;
        end
        if (resp_valid) begin
            if (rec_rv_cnt == 0) rec_rv_cyc = cyc;
            rec_rv_cnt++;
            rec_data  = resp_data;
            rec_wen   = resp_wen;
            rec_err   = resp_err;
            rec_raddr = resp_addr;
        end
    end

    // Byte-wise load model: gather size bytes from off, then extend.
    function automatic logic [31:0] load_model(input logic [31:0] w, input int o, input logic [2:0] f3);
        int          sz;
        logic [63:0] v;
        sz = 1 << f3[1:0];
        v  = 64'd0;
        for (int i = 0; i < sz; i++) v = v | (((64'(w) >> (8 * (o + i))) & 64'hFF) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic set_idle();
        e_req_ready = 1'b1; e_mem_req = 1'b0; e_resp_valid = 1'b0;
    endtask

    // rw < 0: rvalid together with gnt.
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] base, off, wdata,
                           input logic [4:0] rd, input logic [31:0] rdata, input bit rerr,
                           input int gw, input int rw, input int rrw);
        logic [31:0] ea;
        int          sz, o;
        bit          ill, mis;
        ea  = base + off;
        o   = int'(ea[1:0]);
        sz  = 1 << f3[1:0];
        ill = (f3 == 3'd7) || (f3 == 3'd3) || (f3 == 3'd6) || (st && f3[2]);
        mis = !ill && ((ea % sz) != 0);
        txn_id++;
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_base = base;
        req_offset = off; req_wdata = wdata; req_rd = rd;
        set_idle();
        @(posedge clk); #1;
        acc_cyc = cyc - 1;
        req_valid = 1'b0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_base = $urandom; req_offset = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        e_req_ready = 1'b0;
        if (ill || mis) begin
            @(posedge clk); #1;
        end else begin
            e_mem_req = 1'b1; e_we = st; e_addr = {ea[31:2], 2'b00};
            e_strb = 4'd0; e_wdata = 32'd0;
            if (st) begin
                for (int i = 0; i < sz; i++) begin
                    e_strb[o+i] = 1'b1;
                    e_wdata[8*(o+i) +: 8] = wdata[8*i +: 8];
                end
            end
            repeat (gw) begin @(posedge clk); #1; end
            mem_gnt = 1'b1;
            if (!st && rw < 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; mem_rerr = rerr; end
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = $urandom;
            e_mem_req = 1'b0;
            if (!st && rw >= 0) begin
                repeat (rw) begin mem_gnt = 1'($urandom); @(posedge clk); #1; end
                mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata; mem_rerr = rerr;
                @(posedge clk); #1;
                mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = $urandom;
            end
        end
        e_rd = rd; e_raddr = ea; e_resp_valid = 1'b1; e_data = 32'd0; e_wen = 1'b0;
        if (ill)           e_err = 2'b10;
        else if (mis)      e_err = 2'b01;
        else if (st)       e_err = 2'b00;
        else if (rerr)     e_err = 2'b11;
        else begin
            e_err  = 2'b00;
            e_data = load_model(rdata, o, f3);
            e_wen  = (rd != 5'd0);
        end
        repeat (rrw) begin
            resp_ready = 1'b0; mem_rvalid = 1'($urandom); mem_gnt = 1'($urandom);
            mem_rerr = 1'($urandom); mem_rdata = $urandom;
            @(posedge clk); #1;
        end
        resp_ready = 1'b1; mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rerr = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        set_idle();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_resp_addr"}, resp_addr, 0);
        chk({tag, "_req_ready64"}, req_ready6, 1);
    endtask

    logic [63:0] r6_data, r6_addr, r6_wdata, r6_raddr;
    logic [1:0]  r6_err;
    logic        r6_wen, r6_we;
    logic [7:0]  r6_strb;
    logic [4:0]  r6_rd;

    task automatic run64(input bit st, input logic [2:0] f3, input logic [63:0] base, off, wd, rd64,
                         input bit rerr);
        bit ok;
        req_valid6 = 1'b1; req_is_store6 = st; req_funct36 = f3;
        req_base6 = base; req_offset6 = off; req_wdata6 = wd;
        @(posedge clk); #1;
        req_valid6 = 1'b0;
        ok = 1'b0; r6_strb = 8'd0; r6_data = 64'd0; r6_err = 2'd0; r6_wen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!ok) begin
                mem_gnt6 = mem_req6; mem_rvalid6 = mem_req6 & !st;
                mem_rdata6 = rd64; mem_rerr6 = rerr;
                if (mem_req6) begin
                    r6_strb = mem_wstrb6; r6_addr = mem_addr6; r6_wdata = mem_wdata6; r6_we = mem_we6;
                end
                if (resp_valid6) begin
                    r6_data = resp_data6; r6_err = resp_err6; r6_wen = resp_wen6;
                    r6_raddr = resp_addr6; r6_rd = resp_rd6; ok = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        mem_gnt6 = 1'b0; mem_rvalid6 = 1'b0; mem_rerr6 = 1'b0;
        chk("x64_resp_within_budget", ok, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] tgt, base;
        logic [2:0]  f3;
        bit          st;
        rst = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0; req_base = 32'd0;
        req_offset = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; mem_rerr = 1'b0; resp_ready = 1'b0;
        req_valid6 = 1'b0; req_is_store6 = 1'b0; req_funct36 = 3'd0; req_base6 = 64'd0;
        req_offset6 = 64'd0; req_wdata6 = 64'd0;
        mem_gnt6 = 1'b0; mem_rvalid6 = 1'b0; mem_rdata6 = 64'd0; mem_rerr6 = 1'b0;
        set_idle();
        #3 check_reset("init");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; chk_on = 1'b1;

        // LB at EA 0x103 picks byte 3 and sign-extends.
        run_txn(1'b0, 3'b000, 32'h100, 32'd3, 32'd0, 5'd5, 32'h80FF_0000, 1'b0, 0, 1, 0);
        chk("t1_mem_addr", rec_addr, 32'h100);
        chk("t1_resp_data", rec_data, 32'hFFFF_FF80);
        chk("t1_resp_wen", rec_wen, 1);
        chk("t1_resp_err", rec_err, 0);

        run_txn(1'b1, 3'b001, 32'h202, 32'd0, 32'h0000_ABCD, 5'd9, 32'd0, 1'b0, 3, 0, 0);
        chk("t2_wstrb", rec_strb, 4'b1100);
        chk("t2_wdata_hi", rec_wdata[31:16], 16'hABCD);
        chk("t2_mem_req_lat", rec_mr_cyc - acc_cyc, 1);
        chk("t2_resp_lat", rec_rv_cyc - acc_cyc, 5);
        chk("t2_resp_wen", rec_wen, 0);

        run_txn(1'b0, 3'b010, 32'h100, 32'd1, 32'd0, 5'd4, 32'd0, 1'b0, 0, 0, 0);
        chk("t3_resp_err", rec_err, 2'b01);
        chk("t3_resp_addr", rec_raddr, 32'h101);
        chk("t3_no_mem_req", rec_mr_seen, 0);
        chk("t3_resp_lat", rec_rv_cyc - acc_cyc, 2);

        run_txn(1'b0, 3'b101, 32'h0, 32'd6, 32'd0, 5'd0, 32'h8001_0000, 1'b0, 1, 0, 5);
        chk("t4_resp_data", rec_data, 32'h8001);
        chk("t4_resp_wen", rec_wen, 0);
        chk("t4_resp_cycles", rec_rv_cnt, 6);

        run_txn(1'b0, 3'b011, 32'h0, 32'd8, 32'd0, 5'd2, 32'd0, 1'b0, 0, 0, 0);
        chk("t5_ld_on_32", rec_err, 2'b10);

        run_txn(1'b0, 3'b010, 32'h40, 32'd4, 32'd0, 5'd3, 32'h1234_5678, 1'b1, 0, 2, 1);
        chk("t5_bus_err", rec_err, 2'b11);
        chk("t5_bus_err_data", rec_data, 0);

        for (int t = 0; t < 150; t++) begin
            st   = 1'($urandom);
            f3   = 3'($urandom);
            base = $urandom;
            tgt  = $urandom;
            if ($urandom_range(0, 3) != 0) tgt = tgt & ~((32'd1 << f3[1:0]) - 32'd1);
            run_txn(st, f3, base, tgt - base, $urandom, 5'($urandom), $urandom,
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 3),
                    int'($urandom_range(0, 4)) - 1, $urandom_range(0, 3));
        end

        // Reset while waiting for load data; a late rvalid must be ignored.
        txn_id++;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h40;
        req_offset = 32'd0; req_rd = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0; e_req_ready = 1'b0; e_mem_req = 1'b1; e_we = 1'b0;
        e_addr = 32'h40; e_strb = 4'd0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; e_mem_req = 1'b0;
        #1 rst = 1'b1; set_idle();
        #1 check_reset("t6");
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_stale_rvalid", rec_rv_cnt, 0);

        run64(1'b0, 3'b011, 64'h0, 64'h8, 64'd0, 64'hDEAD, 1'b1);
        chk("x64_ld_rerr_err", r6_err, 2'b11);
        chk("x64_ld_rerr_data", r6_data, 0);
        chk("x64_ld_rerr_wen", r6_wen, 0);
        chk("x64_ld_rerr_addr", r6_addr, 64'h8);
        run64(1'b0, 3'b011, 64'h10, 64'h0, 64'd0, 64'h8000_0000_0000_0001, 1'b0);
        chk("x64_ld_data", r6_data, 64'h8000_0000_0000_0001);
        chk("x64_ld_wen", r6_wen, 1);
        chk("x64_ld_rd", r6_rd, 7);
        run64(1'b0, 3'b110, 64'h10, 64'h4, 64'd0, 64'hFFFF_FFFF_1234_5678, 1'b0);
        chk("x64_lwu_data", r6_data, 64'h0000_0000_FFFF_FFFF);
        chk("x64_lwu_raddr", r6_raddr, 64'h14);
        run64(1'b0, 3'b010, 64'h14, 64'h0, 64'd0, 64'hFFFF_FFFF_1234_5678, 1'b0);
        chk("x64_lw_data", r6_data, 64'hFFFF_FFFF_FFFF_FFFF);
        run64(1'b1, 3'b011, 64'h8, 64'h0, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
        chk("x64_sd_strb", r6_strb, 8'hFF);
        chk("x64_sd_wdata", r6_wdata, 64'h1122_3344_5566_7788);
        chk("x64_sd_we", r6_we, 1);
        chk("x64_sd_err", r6_err, 0);
        run64(1'b1, 3'b010, 64'h18, 64'h4, 64'h0000_0000_AABB_CCDD, 64'd0, 1'b0);
        chk("x64_sw_strb", r6_strb, 8'hF0);
        chk("x64_sw_wdata_hi", r6_wdata[63:32], 32'hAABB_CCDD);
        run64(1'b1, 3'b100, 64'h20, 64'h0, 64'd0, 64'd0, 1'b0);
        chk("x64_store_1xx_err", r6_err, 2'b10);
        run64(1'b0, 3'b001, 64'h20, 64'h3, 64'd0, 64'd0, 1'b0);
        chk("x64_lh_misaligned", r6_err, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
